// File: rtl/alu_vector_checker_if.sv
// alu_vector_checker_if: vector ROM read port and DUT drive/response bus of the checker.
// master is the checker side; slave is the ROM + ALU side.
interface alu_vector_checker_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] vec_addr;
    logic [DATA_W-1:0] vec_src1, vec_src2, vec_result;
    logic [3:0]        vec_op;
    logic [2:0]        vec_bonus, vec_zcv;
    logic [DATA_W-1:0] dut_src1, dut_src2, dut_result;
    logic [3:0]        dut_op;
    logic [2:0]        dut_bonus, dut_zcv;

    modport master (
        output vec_addr, dut_src1, dut_src2, dut_op, dut_bonus,
        input  vec_src1, vec_src2, vec_op, vec_bonus, vec_result, vec_zcv, dut_result, dut_zcv
    );
    modport slave (
        input  vec_addr, dut_src1, dut_src2, dut_op, dut_bonus,
        output vec_src1, vec_src2, vec_op, vec_bonus, vec_result, vec_zcv, dut_result, dut_zcv
    );
endinterface

// File: rtl/alu_vector_checker.sv
// alu_vector_checker: replays ROM vectors into an ALU one per cycle and checks its
// result/flags after DUT_LAT cycles, counting mismatches and reporting pass/fail.
module alu_vector_checker #(
    parameter int DATA_W  = 32,
    parameter int PAT_N   = 16,
    parameter int ADDR_W  = 4,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    alu_vector_checker_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_pulse,
    output logic [ADDR_W-1:0] err_idx,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_vld,
    output logic [ADDR_W-1:0] first_err_idx
);
    localparam int L = DUT_LAT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PAT_N - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic              go, issue, cmp, last_cmp, full, mis;
    logic [L:0]        p_vld;
    logic [ADDR_W-1:0] p_idx [L+1];
    logic [DATA_W-1:0] p_res [L+1];
    logic [2:0]        p_zcv [L+1];
    logic [3:0]        p_op  [L+1];

    assign go       = start && !abort && (state == IDLE || state == DONE);
    assign issue    = state == FETCH && !abort;
    assign cmp      = p_vld[L] && !abort;
    assign last_cmp = cmp && p_idx[L] == LAST;
    // ADD and SUB check all flags; every other op only checks zero
    assign full     = p_op[L] == 4'd2 || p_op[L] == 4'd6;
    assign mis      = bus.dut_result != p_res[L] ||
                      (full ? bus.dut_zcv != p_zcv[L] : bus.dut_zcv[2] != p_zcv[L][2]);

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;

    always_comb
        state_nx = abort ? IDLE :
                   go ? FETCH :
                   (state == FETCH && bus.vec_addr == LAST) ? DRAIN :
                   (state == DRAIN && last_cmp) ? DONE : state;

    always_comb begin
        busy = state == FETCH || state == DRAIN;
        done = state == DONE;
        pass = done && err_count == '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.vec_addr  <= '0;
            bus.dut_src1  <= '0;
            bus.dut_src2  <= '0;
            bus.dut_op    <= '0;
            bus.dut_bonus <= '0;
            p_vld         <= '0;
            err_pulse     <= 1'b0;
            err_idx       <= '0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else begin
            err_pulse <= cmp && mis;
            p_vld[0]  <= issue;
            for (int k = L; k > 0; k--)
                p_vld[k] <= p_vld[k-1] && !abort;
            if (issue) begin
                bus.dut_src1  <= bus.vec_src1;
                bus.dut_src2  <= bus.vec_src2;
                bus.dut_op    <= bus.vec_op;
                bus.dut_bonus <= bus.vec_bonus;
            end
            if (go)
                bus.vec_addr <= '0;
            else if (issue && bus.vec_addr != LAST)
                bus.vec_addr <= bus.vec_addr + ADDR_W'(1);
            if (go) begin
                err_count     <= '0;
                first_err_vld <= 1'b0;
                first_err_idx <= '0;
            end else if (cmp && mis) begin
                err_idx   <= p_idx[L];
                err_count <= err_count == '1 ? err_count : err_count + ERR_W'(1);
                if (!first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_idx <= p_idx[L];
                end
            end
        end
    end

    // expected values ride alongside the DUT pipeline so they meet its output
    always_ff @(posedge clk) begin
        for (int k = L; k > 0; k--) begin
            p_idx[k] <= p_idx[k-1];
            p_res[k] <= p_res[k-1];
            p_zcv[k] <= p_zcv[k-1];
            p_op[k]  <= p_op[k-1];
        end
        if (issue) begin
            p_idx[0] <= bus.vec_addr;
            p_res[0] <= bus.vec_result;
            p_zcv[0] <= bus.vec_zcv;
            p_op[0]  <= bus.vec_op;
        end
    end
endmodule

// File: tb/tb_alu_vector_checker.sv
// tb_alu_vector_checker: a combinational ALU (PAT_N=4) and a 2-stage ALU (PAT_N=8, ERR_W=2)
// checked against a scoreboard of expected per-vector compare outcomes.
module tb_alu_vector_checker;
    typedef struct packed {
        logic [31:0] s1, s2;
        logic [3:0]  op;
        logic [2:0]  bo;
        logic [31:0] res;
        logic [2:0]  zcv;
    } vec_t;
    typedef struct {
        int due;
        bit mis;
        int idx;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start [2], abort [2], busy [2], done [2], pass [2], epulse [2], fvld [2];
    logic [3:0]  eidx [2], fidx [2], vaddr [2];
    logic [31:0] dsrc [2];
    logic [7:0]  ecnt_a, ec [2];
    logic [1:0]  ecnt_b;
    logic [34:0] pipe1, pipe2;
    vec_t        rom [2][16];
    exp_t        qa [$], qb [$], ea, eb;
    int          total = 0, bad = 0, cyc = 0;

    alu_vector_checker_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
    alu_vector_checker_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();

    alu_vector_checker #(.DATA_W(32), .PAT_N(4), .ADDR_W(4), .DUT_LAT(0), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .bus(bus_a),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_pulse(epulse[0]), .err_idx(eidx[0]),
        .err_count(ecnt_a), .first_err_vld(fvld[0]), .first_err_idx(fidx[0])
    );
    alu_vector_checker #(.DATA_W(32), .PAT_N(8), .ADDR_W(4), .DUT_LAT(2), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .bus(bus_b),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_pulse(epulse[1]), .err_idx(eidx[1]),
        .err_count(ecnt_b), .first_err_vld(fvld[1]), .first_err_idx(fidx[1])
    );

    function automatic logic [34:0] alu(logic [3:0] op, logic [2:0] bo, logic [31:0] a, logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        v;
        w = '0;
        v = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin w = {1'b0, a} + {1'b0, b}; v = a[31] == b[31] && w[31] != a[31]; end
            4'd6: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; v = a[31] != b[31] && w[31] != a[31]; end
            4'd7: r = {31'd0, $signed(a) < $signed(b)};
            default: r = ~(a | b) ^ {29'd0, bo};
        endcase
        if (op == 4'd2 || op == 4'd6) r = w[31:0];
        return {r, r == 32'd0, w[32], v};
    endfunction

    function automatic vec_t mk(logic [3:0] op, logic [2:0] bo, logic [31:0] a, logic [31:0] b);
        logic [34:0] g;
        vec_t v;
        g = alu(op, bo, a, b);
        v.s1 = a; v.s2 = b; v.op = op; v.bo = bo; v.res = g[34:3]; v.zcv = g[2:0];
        return v;
    endfunction

    function automatic bit exp_mis(vec_t v);
        logic [34:0] g;
        g = alu(v.op, v.bo, v.s1, v.s2);
        if (g[34:3] != v.res) return 1'b1;
        return (v.op == 4'd2 || v.op == 4'd6) ? g[2:0] != v.zcv : g[2] != v.zcv[2];
    endfunction

    function automatic logic [3:0] opsel(int i);
        return i % 6 == 0 ? 4'd0 : i % 6 == 1 ? 4'd1 : i % 6 == 2 ? 4'd2 :
               i % 6 == 3 ? 4'd6 : i % 6 == 4 ? 4'd7 : 4'd12;
    endfunction

    function automatic string pre(int b);
        return b != 0 ? "b_" : "a_";
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic fill(int b);
        for (int i = 0; i < 16; i++)
            rom[b][i] = mk(opsel(i), 3'($urandom), $urandom, $urandom);
    endtask

    task automatic push(input int b, input int e0, input int n, output int nerr, output int first);
        exp_t e;
        nerr = 0;
        first = 0;
        for (int i = 0; i < n; i++) begin
            e.due = e0 + i + 2 + (b != 0 ? 2 : 0);
            e.mis = exp_mis(rom[b][i]);
            e.idx = i;
            if (e.mis && nerr == 0) first = i;
            if (e.mis) nerr++;
            if (b != 0) qb.push_back(e); else qa.push_back(e);
        end
    endtask

    task automatic zeros(int b);
        chk({pre(b), "rst_addr"}, vaddr[b], 0);
        chk({pre(b), "rst_src1"}, dsrc[b], 0);
        chk({pre(b), "rst_busy"}, busy[b], 0);
        chk({pre(b), "rst_done"}, done[b], 0);
        chk({pre(b), "rst_pass"}, pass[b], 0);
        chk({pre(b), "rst_pulse"}, epulse[b], 0);
        chk({pre(b), "rst_eidx"}, eidx[b], 0);
        chk({pre(b), "rst_cnt"}, ec[b], 0);
        chk({pre(b), "rst_fvld"}, fvld[b], 0);
        chk({pre(b), "rst_fidx"}, fidx[b], 0);
    endtask

    task automatic run(input int b, input bit poke);
        int n, l, sat, e0, nerr, first, t;
        n = b != 0 ? 8 : 4;
        l = b != 0 ? 2 : 0;
        sat = b != 0 ? 3 : 255;
        t = 0;
        @(negedge clk);
        start[b] = 1'b1;
        e0 = cyc + 1;
        push(b, e0, n, nerr, first);
        @(negedge clk);
        start[b] = 1'b0;
        chk({pre(b), "addr0"}, vaddr[b], 0);
        chk({pre(b), "busy"}, busy[b], 1);
        while (!done[b] && t < 40) begin
            start[b] = poke && t == 1;
            @(negedge clk);
            t++;
        end
        start[b] = 1'b0;
        #1;
        chk({pre(b), "done"}, done[b], 1);
        chk({pre(b), "done_edge"}, cyc - e0, n + 1 + l);
        chk({pre(b), "busy_end"}, busy[b], 0);
        chk({pre(b), "pass"}, pass[b], nerr == 0);
        chk({pre(b), "cnt"}, ec[b], nerr > sat ? sat : nerr);
        chk({pre(b), "fvld"}, fvld[b], nerr != 0);
        chk({pre(b), "fidx"}, fidx[b], first);
        chk({pre(b), "addr_hold"}, vaddr[b], n - 1);
        chk({pre(b), "src_hold"}, dsrc[b], rom[b][n-1].s1);
        chk({pre(b), "sb_left"}, b != 0 ? qb.size() : qa.size(), 0);
    endtask

    assign vaddr[0] = bus_a.vec_addr;
    assign vaddr[1] = bus_b.vec_addr;
    assign dsrc[0]  = bus_a.dut_src1;
    assign dsrc[1]  = bus_b.dut_src1;
    assign ec[0]    = ecnt_a;
    assign ec[1]    = {6'd0, ecnt_b};

    assign bus_a.vec_src1   = rom[0][bus_a.vec_addr].s1;
    assign bus_a.vec_src2   = rom[0][bus_a.vec_addr].s2;
    assign bus_a.vec_op     = rom[0][bus_a.vec_addr].op;
    assign bus_a.vec_bonus  = rom[0][bus_a.vec_addr].bo;
    assign bus_a.vec_result = rom[0][bus_a.vec_addr].res;
    assign bus_a.vec_zcv    = rom[0][bus_a.vec_addr].zcv;
    assign bus_b.vec_src1   = rom[1][bus_b.vec_addr].s1;
    assign bus_b.vec_src2   = rom[1][bus_b.vec_addr].s2;
    assign bus_b.vec_op     = rom[1][bus_b.vec_addr].op;
    assign bus_b.vec_bonus  = rom[1][bus_b.vec_addr].bo;
    assign bus_b.vec_result = rom[1][bus_b.vec_addr].res;
    assign bus_b.vec_zcv    = rom[1][bus_b.vec_addr].zcv;

    assign {bus_a.dut_result, bus_a.dut_zcv} = alu(bus_a.dut_op, bus_a.dut_bonus, bus_a.dut_src1, bus_a.dut_src2);
    always @(posedge clk) begin
        pipe1 <= alu(bus_b.dut_op, bus_b.dut_bonus, bus_b.dut_src1, bus_b.dut_src2);
        pipe2 <= pipe1;
    end
    assign {bus_b.dut_result, bus_b.dut_zcv} = pipe2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rst_n) begin
        if (qa.size() != 0 && qa[0].due == cyc) begin
            ea = qa.pop_front();
            chk("a_pulse", epulse[0], ea.mis);
            if (ea.mis) chk("a_eidx", eidx[0], ea.idx);
        end else if (epulse[0]) chk("a_spur", epulse[0], 0);
    end

    always @(negedge clk) if (rst_n) begin
        if (qb.size() != 0 && qb[0].due == cyc) begin
            eb = qb.pop_front();
            chk("b_pulse", epulse[1], eb.mis);
            if (eb.mis) chk("b_eidx", eidx[1], eb.idx);
        end else if (epulse[1]) chk("b_spur", epulse[1], 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int e0, nerr, first;
        for (int b = 0; b < 2; b++) begin
            start[b] = 1'b0;
            abort[b] = 1'b0;
        end
        fill(0);
        fill(1);
        repeat (3) @(negedge clk);
        zeros(0);
        zeros(1);
        #1 rst_n = 1'b1;
        run(0, 1'b1);
        rom[0][2] = mk(4'd2, 3'd0, 32'd1, 32'd3);
        rom[0][2].res = 32'd5;
        run(0, 1'b0);
        fill(0);
        rom[0][0] = mk(4'd0, 3'd0, 32'd0, 32'h1234);
        rom[0][0].zcv = 3'b110;
        rom[0][2] = mk(4'd2, 3'd0, 32'd1, 32'd3);
        rom[0][2].zcv ^= 3'b010;
        run(0, 1'b0);
        @(negedge clk);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk("a_abst_busy", busy[0], 0);
        chk("a_abst_done", done[0], 0);
        chk("a_abst_cnt", ec[0], 1);
        fill(0);
        rom[0][0].res ^= 32'h1;
        @(negedge clk);
        start[0] = 1'b1;
        e0 = cyc + 1;
        push(0, e0, 2, nerr, first);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("a_abort_busy", busy[0], 0);
        chk("a_abort_done", done[0], 0);
        chk("a_abort_pass", pass[0], 0);
        chk("a_abort_cnt", ec[0], 1);
        chk("a_abort_fvld", fvld[0], 1);
        chk("a_abort_fidx", fidx[0], 0);
        fill(0);
        run(0, 1'b0);
        fill(1);
        run(1, 1'b0);
        for (int i = 0; i < 8; i++) rom[1][i].res ^= 32'h8;
        run(1, 1'b0);
        @(negedge clk);
        start[1] = 1'b1;
        e0 = cyc + 1;
        push(1, e0, 8, nerr, first);
        @(negedge clk);
        start[1] = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        zeros(0);
        zeros(1);
        qb.delete();
        #1 rst_n = 1'b1;
        fill(1);
        run(1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
